// File: rtl/display_barcos.sv
// -----------------------------------------------------------------------------
// display_barcos : per-player 7-segment display of ships alive, with blink on loss
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module display_barcos #(
   parameter int N_BARCOS     = 5,
   parameter int N_JUGADORES  = 2,
   parameter int BLINK_CICLOS = 25_000_000,
   parameter int BLINK_VECES  = 3
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_JUGADORES*N_BARCOS-1:0] barcos,
   output logic [N_JUGADORES*7-1:0]        segmentos,
   output logic [N_JUGADORES-1:0]          hundido,
   output logic [N_JUGADORES-1:0]          derrota
);

   localparam int CW = $clog2(N_BARCOS + 1);
   localparam int PW = (BLINK_CICLOS > 1) ? $clog2(BLINK_CICLOS) : 1;
   localparam int VW = (BLINK_VECES > 1) ? $clog2(BLINK_VECES) : 1;

   localparam logic [PW-1:0] PH_LAST  = PW'(BLINK_CICLOS - 1);
   localparam logic [VW-1:0] OFF_LAST = VW'(BLINK_VECES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(N_BARCOS);
   localparam logic [6:0]    BLANK    = 7'b1111111;

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      APAGADO   = 2'd1,
      ENCENDIDO = 2'd2
   } estado_t;

   function automatic logic [6:0] digito(input logic [3:0] v);
      case (v)
         4'd0:    digito = 7'b0000001;
         4'd1:    digito = 7'b1001111;
         4'd2:    digito = 7'b0010010;
         4'd3:    digito = 7'b0000110;
         4'd4:    digito = 7'b1001100;
         4'd5:    digito = 7'b0100100;
         4'd6:    digito = 7'b0100000;
         4'd7:    digito = 7'b0001111;
         4'd8:    digito = 7'b0000000;
         4'd9:    digito = 7'b0000100;
         default: digito = BLANK;
      endcase
   endfunction

   logic [N_JUGADORES*N_BARCOS-1:0] r_barcos;

   always_ff @(posedge clk) begin
      if (rst) r_barcos <= '1;
      else     r_barcos <= barcos;
   end

   for (genvar j = 0; j < N_JUGADORES; j++) begin : g_canal
      estado_t       r_st, w_st_n;
      logic [CW-1:0] r_cuenta, w_cuenta_n, w_count;
      logic [PW-1:0] r_ph, w_ph_n;
      logic [VW-1:0] r_off, w_off_n;
      logic          r_hund, r_derr;
      logic [6:0]    r_seg;

      // Position-independent popcount of this player's alive mask
      always_comb begin
         w_count = '0;
         for (int b = 0; b < N_BARCOS; b++)
            w_count = w_count + CW'(r_barcos[j*N_BARCOS + b]);
      end

      // A loss outranks any timer transition and restarts the blink sequence
      always_comb begin
         w_st_n     = r_st;
         w_cuenta_n = r_cuenta;
         w_ph_n     = r_ph;
         w_off_n    = r_off;
         if (w_count < r_cuenta) begin
            w_cuenta_n = w_count;
            w_st_n     = APAGADO;
            w_ph_n     = '0;
            w_off_n    = '0;
         end else if (w_count > r_cuenta) begin
            w_cuenta_n = w_count;
            w_st_n     = NORMAL;
            w_ph_n     = '0;
            w_off_n    = '0;
         end else begin
            case (r_st)
               APAGADO: begin
                  if (r_ph == PH_LAST) begin
                     w_st_n = ENCENDIDO;
                     w_ph_n = '0;
                  end else begin
                     w_ph_n = r_ph + PW'(1);
                  end
               end
               ENCENDIDO: begin
                  if (r_ph == PH_LAST) begin
                     w_ph_n = '0;
                     if (r_off == OFF_LAST) begin
                        w_st_n  = NORMAL;
                        w_off_n = '0;
                     end else begin
                        w_st_n  = APAGADO;
                        w_off_n = r_off + VW'(1);
                     end
                  end else begin
                     w_ph_n = r_ph + PW'(1);
                  end
               end
               default: begin
                  w_st_n  = NORMAL;
                  w_ph_n  = '0;
                  w_off_n = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_st     <= NORMAL;
            r_cuenta <= CNT_MAX;
            r_ph     <= '0;
            r_off    <= '0;
            r_hund   <= 1'b0;
            r_derr   <= 1'b0;
            r_seg    <= digito(4'(CNT_MAX));
         end else begin
            r_st     <= w_st_n;
            r_cuenta <= w_cuenta_n;
            r_ph     <= w_ph_n;
            r_off    <= w_off_n;
            r_hund   <= (w_count < r_cuenta);
            r_derr   <= (w_cuenta_n == '0);
            r_seg    <= (w_st_n == APAGADO) ? BLANK : digito(4'(w_cuenta_n));
         end
      end

      assign segmentos[j*7 +: 7] = r_seg;
      assign hundido[j]          = r_hund;
      assign derrota[j]          = r_derr;
   end

endmodule

`default_nettype wire
